// File: rtl/tcp_vlg_tx_arb.sv
// tcp_vlg_tx_arb
// Shares a single tcp_vlg_tx packet transmitter between N packet sources.
// A ready source is picked round-robin, its metadata is latched, and the
// rdy/acc/req/done handshake plus the payload byte stream are routed between
// that source and the transmitter. One packet is in flight at a time and the
// grant is held until the transmitter reports done.
//
// Build option: define TCP_VLG_TX_ARB_PRIO0_EN to give source 0 strict
// priority; the remaining sources then share round-robin among themselves.

typedef struct packed {
  logic [31:0] seq;
  logic [31:0] ack;
  logic [7:0]  flags;
  logic [15:0] pld_len;
} tcp_meta_t;

module tcp_vlg_tx_arb #(
  parameter  int N     = 3,
  localparam int IDX_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic      [N-1:0]    src_rdy,
  input  tcp_meta_t [N-1:0]    src_meta,
  output logic      [N-1:0]    src_acc,
  output logic      [N-1:0]    src_req,
  input  logic      [N-1:0][7:0] src_dat,
  output logic      [N-1:0]    src_done,
  output logic                 tx_rdy,
  output tcp_meta_t            tx_meta,
  input  logic                 tx_acc,
  input  logic                 tx_req,
  output logic      [7:0]      tx_dat,
  input  logic                 tx_done,
  output logic                 busy,
  output logic      [IDX_W-1:0] grant_idx
);

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    ACTIVE,
    RELEASE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] scan_idx;
  logic             found;
  logic [N-1:0]     cand;
  logic [N-1:0]     grant_oh;
  logic             upd_last;

  assign grant_oh = N'(1) << grant_idx;

`ifdef TCP_VLG_TX_ARB_PRIO0_EN
  // Source 0 is handled outside the rotation, so it is removed from the candidates
  always_comb begin
    cand    = src_rdy;
    cand[0] = 1'b0;
  end

  // Grants to source 0 must not disturb the rotation pointer of the others
  assign upd_last = (grant_idx != '0);
`else
  // Every source takes part in the rotation
  always_comb begin
    cand = src_rdy;
  end

  // Every finished grant advances the rotation pointer
  assign upd_last = 1'b1;
`endif

  // Scan candidates starting just after the last granted index, wrapping at N-1
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = last_grant;
    for (int k = 0; k < N; k++) begin
      scan_idx = (scan_idx == IDX_W'(N - 1)) ? '0 : scan_idx + IDX_W'(1);
      if (!found && cand[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
`ifdef TCP_VLG_TX_ARB_PRIO0_EN
    if (src_rdy[0]) begin
      winner = '0;
    end
`endif
  end

  // Grant FSM: latch winner and metadata, offer, stream, then one release cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= IDX_W'(N - 1);
      grant_idx  <= '0;
      tx_meta    <= '0;
      tx_rdy     <= 1'b0;
      busy       <= 1'b0;
      src_acc    <= '0;
      src_done   <= '0;
    end else begin
      src_acc  <= '0;
      src_done <= '0;
      case (state)
        IDLE: begin
          if (|src_rdy) begin
            grant_idx <= winner;
            tx_meta   <= src_meta[winner];
            tx_rdy    <= 1'b1;
            busy      <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (tx_done) begin
            tx_rdy   <= 1'b0;
            src_done <= grant_oh;
            if (tx_acc) begin
              src_acc <= grant_oh;
            end
            if (upd_last) begin
              last_grant <= grant_idx;
            end
            state <= RELEASE;
          end else if (tx_acc) begin
            tx_rdy  <= 1'b0;
            src_acc <= grant_oh;
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (tx_done) begin
            src_done <= grant_oh;
            if (upd_last) begin
              last_grant <= grant_idx;
            end
            state <= RELEASE;
          end
        end
        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Payload path: route request and data only to the granted source while streaming
  always_comb begin
    src_req = '0;
    tx_dat  = '0;
    if (state == ACTIVE) begin
      src_req = grant_oh & {N{tx_req}};
      tx_dat  = src_dat[grant_idx];
    end
  end

endmodule

// File: tb/tb_tcp_vlg_tx_arb.sv
// tb_tcp_vlg_tx_arb
// Directed bench for tcp_vlg_tx_arb. Stimulus tasks push the expected events
// (grant, accept pulse, payload byte, done pulse) into a queue; a monitor on the
// falling clock edge pops and compares whenever the arbiter presents one.
// Expected grant orders follow TCP_VLG_TX_ARB_PRIO0_EN when it is defined.

module tb_tcp_vlg_tx_arb;

  localparam int N = 3;

  typedef struct packed {
    logic [31:0] seq;
    logic [31:0] ack;
    logic [7:0]  flags;
    logic [15:0] pld_len;
  } meta_t;

  typedef enum int {EV_GRANT, EV_ACC, EV_BYTE, EV_DONE} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    int          idx;
    logic [7:0]  dat;
    meta_t       meta;
  } ev_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       src_rdy;
  meta_t [N-1:0]      src_meta;
  logic [N-1:0]       src_acc;
  logic [N-1:0]       src_req;
  logic [N-1:0][7:0]  src_dat;
  logic [N-1:0]       src_done;
  logic               tx_rdy;
  meta_t              tx_meta;
  logic               tx_acc;
  logic               tx_req;
  logic [7:0]         tx_dat;
  logic               tx_done;
  logic               busy;
  logic [1:0]         grant_idx;

  ev_t   exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    cur_gen = 0;
  logic  prev_rdy = 1'b0;
  meta_t cur_meta = '0;
  bit    cur_valid = 1'b0;

`ifdef TCP_VLG_TX_ARB_PRIO0_EN
  int t3_exp [6] = '{0, 0, 0, 0, 0, 0};
`else
  int t3_exp [6] = '{0, 1, 2, 0, 1, 2};
`endif

  tcp_vlg_tx_arb #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_rdy   (src_rdy),
    .src_meta  (src_meta),
    .src_acc   (src_acc),
    .src_req   (src_req),
    .src_dat   (src_dat),
    .src_done  (src_done),
    .tx_rdy    (tx_rdy),
    .tx_meta   (tx_meta),
    .tx_acc    (tx_acc),
    .tx_req    (tx_req),
    .tx_dat    (tx_dat),
    .tx_done   (tx_done),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic meta_t mk_meta(input int i, input int gen);
    meta_t m;
    m.seq     = ((32'(i) + 32'd1) << 28) | 32'(gen);
    m.ack     = 32'hA000_0000 + 32'(gen * 16 + i);
    m.flags   = 8'(gen);
    m.pld_len = 16'd4;
    return m;
  endfunction

  function automatic logic [7:0] dat_of(input int i, input int b);
    return 8'((i + 1) * 16 + b);
  endfunction

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] out_bundle();
    return 128'({tx_rdy, busy, grant_idx, src_acc, src_done, src_req, tx_dat, tx_meta});
  endfunction

  task automatic push_ev(input ev_kind_t k, input int idx, input logic [7:0] d, input meta_t m);
    ev_t e;
    e.kind = k;
    e.idx  = idx;
    e.dat  = d;
    e.meta = m;
    exp_q.push_back(e);
  endtask

  // Monitor: pop one expected event per observed DUT event and compare
  task automatic mon_event(input ev_kind_t kind, input int act_idx, input logic [N-1:0] act_vec,
                           input logic [7:0] act_dat, input meta_t act_meta);
    ev_t          e;
    logic [N-1:0] exp_vec;
    bit           bad;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("[TB] FAIL %s unexpected: idx=%0d vec=%b, nothing expected", kind.name(), act_idx, act_vec);
      return;
    end
    e       = exp_q.pop_front();
    exp_vec = N'(1) << e.idx;
    bad     = (e.kind != kind);
    case (kind)
      EV_GRANT: bad = bad || (act_idx != e.idx) || (act_meta !== e.meta);
      EV_BYTE:  bad = bad || (act_vec !== exp_vec) || (act_dat !== e.dat);
      default:  bad = bad || (act_vec !== exp_vec);
    endcase
    if (kind == EV_GRANT && e.kind == EV_GRANT) begin
      cur_meta  = e.meta;
      cur_valid = 1'b1;
    end
    if (bad) begin
      n_err++;
      $display("[TB] FAIL %s: got idx=%0d vec=%b dat=%h meta=%h, expected %s idx=%0d vec=%b dat=%h meta=%h",
               kind.name(), act_idx, act_vec, act_dat, act_meta,
               e.kind.name(), e.idx, exp_vec, e.dat, e.meta);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (tx_rdy && !prev_rdy) mon_event(EV_GRANT, int'(grant_idx), '0, 8'h00, tx_meta);
      if (src_acc != '0)       mon_event(EV_ACC, 0, src_acc, 8'h00, tx_meta);
      if (tx_req)              mon_event(EV_BYTE, 0, src_req, tx_dat, tx_meta);
      if (src_done != '0)      mon_event(EV_DONE, 0, src_done, 8'h00, tx_meta);
      if (busy && cur_valid) begin
        n_cmp++;
        if (tx_meta !== cur_meta) begin
          n_err++;
          $display("[TB] FAIL meta_hold: got %h, expected %h", tx_meta, cur_meta);
        end
      end
    end
    prev_rdy = tx_rdy;
  end

  task automatic set_meta(input int gen);
    cur_gen = gen;
    for (int i = 0; i < N; i++) src_meta[i] = mk_meta(i, gen);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic wait_rdy(output bit ok);
    int k;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!tx_rdy && k < 20);
    ok = tx_rdy;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL tx_rdy_timeout: got tx_rdy=0 after %0d cycles, expected 1", k);
    end
  endtask

  // mode 0: normal packet, 1: done before accept, 2: accept and done together
  task automatic send_pkt(input int exp_idx, input logic [N-1:0] next_rdy, input int acc_dly,
                          input int nbytes, input int mode, input bit scramble, output int rise_cyc);
    bit ok;
    int k;
    rise_cyc = -1;
    push_ev(EV_GRANT, exp_idx, 8'h00, mk_meta(exp_idx, cur_gen));
    wait_rdy(ok);
    if (!ok) begin
      exp_q.delete(exp_q.size() - 1);
      return;
    end
    rise_cyc = cyc;
    if (scramble) src_meta[exp_idx] = mk_meta(exp_idx, 238);
    repeat (acc_dly) begin
      @(posedge clk); #1;
    end
    if (mode == 1) begin
      push_ev(EV_DONE, exp_idx, 8'h00, '0);
      tx_done = 1'b1;
    end else begin
      push_ev(EV_ACC, exp_idx, 8'h00, '0);
      tx_acc = 1'b1;
      if (mode == 2) begin
        push_ev(EV_DONE, exp_idx, 8'h00, '0);
        tx_done = 1'b1;
      end
    end
    @(posedge clk); #1;
    tx_acc  = 1'b0;
    tx_done = 1'b0;
    src_rdy = next_rdy;
    if (mode == 0) begin
      if (scramble) src_meta[exp_idx] = mk_meta(exp_idx, 221);
      for (int b = 0; b < nbytes; b++) begin
        for (int i = 0; i < N; i++) src_dat[i] = dat_of(i, b);
        push_ev(EV_BYTE, exp_idx, dat_of(exp_idx, b), '0);
        tx_req = 1'b1;
        @(posedge clk); #1;
      end
      tx_req = 1'b0;
      push_ev(EV_DONE, exp_idx, 8'h00, '0);
      tx_done = 1'b1;
      @(posedge clk); #1;
      tx_done = 1'b0;
    end
    k = 0;
    while (busy && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) begin
      n_cmp++;
      n_err++;
      $display("[TB] FAIL busy_release: got busy=1 after %0d cycles, expected 0", k);
    end
  endtask

  // Directed test sequence
  initial begin
    int  r0, r1, t0;
    bit  ok;
    src_rdy = '0;
    tx_acc  = 1'b0;
    tx_req  = 1'b0;
    tx_done = 1'b0;
    src_dat = '0;
    set_meta(1);
    rst = 1'b0;

    // Reset state, held and after release with nothing pending
    repeat (3) @(posedge clk);
    #1;
    check_vec("reset_held_outputs", out_bundle(), 128'd0);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check_vec("reset_idle_outputs", out_bundle(), 128'd0);
    end

    // Single packet from source 1
    set_meta(1);
    src_rdy = 3'b010;
    t0 = cyc;
    send_pkt(1, 3'b000, 2, 4, 0, 1'b0, r0);
    check_int("single_rdy_latency", r0 - t0, 1);
    check_int("single_busy_low", int'(busy), 0);

    // Round-robin with all sources held ready, then source 0 drops out
    do_reset();
    set_meta(2);
    src_rdy = 3'b111;
    for (int p = 0; p < 6; p++) send_pkt(t3_exp[p], (p == 5) ? 3'b110 : 3'b111, 0, 2, 0, 1'b0, r0);
    send_pkt(1, 3'b110, 0, 1, 0, 1'b0, r0);
    send_pkt(2, 3'b110, 0, 1, 0, 1'b0, r0);
    send_pkt(1, 3'b000, 0, 1, 0, 1'b0, r0);

    // Wrap after last grant 2, then back-to-back regrant of a lone source
    set_meta(3);
    src_rdy = 3'b100;
    send_pkt(2, 3'b000, 1, 1, 0, 1'b0, r0);
    src_rdy = 3'b101;
    send_pkt(0, 3'b100, 0, 1, 0, 1'b0, r0);
    send_pkt(2, 3'b001, 0, 1, 0, 1'b0, r0);
    send_pkt(0, 3'b001, 0, 0, 0, 1'b0, r0);
    send_pkt(0, 3'b000, 0, 0, 0, 1'b0, r1);
    check_int("regrant_gap", r1 - r0, 4);

    // Metadata changes during OFFER and ACTIVE must not reach tx_meta
    set_meta(4);
    src_rdy = 3'b010;
    send_pkt(1, 3'b000, 3, 2, 0, 1'b1, r0);

    // Done before accept, then accept and done in the same cycle
    set_meta(5);
    src_rdy = 3'b001;
    send_pkt(0, 3'b000, 1, 0, 1, 1'b0, r0);
    src_rdy = 3'b100;
    send_pkt(2, 3'b000, 0, 0, 2, 1'b0, r0);

    // Asynchronous reset in the middle of a packet
    set_meta(6);
    src_rdy = 3'b010;
    push_ev(EV_GRANT, 1, 8'h00, mk_meta(1, 6));
    wait_rdy(ok);
    if (ok) begin
      push_ev(EV_ACC, 1, 8'h00, '0);
      tx_acc = 1'b1;
      @(posedge clk); #1;
      tx_acc  = 1'b0;
      src_rdy = 3'b000;
      @(posedge clk); #1;
    end else begin
      exp_q.delete(exp_q.size() - 1);
    end
    rst = 1'b0;
    #1;
    check_vec("midpkt_reset_outputs", out_bundle(), 128'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    set_meta(7);
    src_rdy = 3'b011;
    send_pkt(0, 3'b010, 0, 1, 0, 1'b0, r0);
    send_pkt(1, 3'b000, 0, 1, 0, 1'b0, r0);

    repeat (3) @(posedge clk);
    #1;
    check_int("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit in case the sequence stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
